// File: rtl/pll_underclock_seq_if.sv
// pll_underclock_seq_if: Avalon-MM write channel to the PLL reconfiguration slave
// master: mgmt_write, mgmt_address[5:0], mgmt_writedata[31:0] out; mgmt_waitrequest in
// slave:  the same signals with opposite directions
interface pll_underclock_seq_if;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  modport master(output mgmt_write, mgmt_address, mgmt_writedata, input mgmt_waitrequest);
  modport slave(input mgmt_write, mgmt_address, mgmt_writedata, output mgmt_waitrequest);
endinterface

// File: rtl/pll_underclock_seq.sv
// pll_underclock_seq: writes mode/frac-K/start to the PLL reconfig slave on speed changes
// clk_50m, reset (async, active-low), underclock_req (async speed select)
// bus: Avalon-MM master to the PLL; busy, applied, done (pulse), cfg_error (sticky timeout)
// PLL_SEQ_TIMEOUT_EN enables the waitrequest watchdog; otherwise writes wait forever
module pll_underclock_seq #(
  parameter logic [31:0] FRAC_NATIVE    = 32'd3639383488,
  parameter logic [31:0] FRAC_UNDER     = 32'd3268298314,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic                 clk_50m,
  input  logic                 reset,
  input  logic                 underclock_req,
  pll_underclock_seq_if.master bus,
  output logic                 busy,
  output logic                 applied,
  output logic                 done,
  output logic                 cfg_error
);
  typedef enum logic [2:0] {IDLE, WR_MODE, GAP1, WR_FRAC, GAP2, WR_START, FINISH} state_t;
  state_t state, state_n;
  logic s1, s2, target, wr, abort;
  assign wr = state inside {WR_MODE, WR_FRAC, WR_START};
  assign busy = state != IDLE;
  // Outputs decode from state only, so an async reset drops mgmt_write at once
  assign bus.mgmt_write = wr;
  assign bus.mgmt_address = state == WR_FRAC ? 6'd7 : state == WR_START ? 6'd2 : 6'd0;
  assign bus.mgmt_writedata = state == WR_FRAC ? (target ? FRAC_UNDER : FRAC_NATIVE) : 32'd0;
  always_ff @(posedge clk_50m or negedge reset)
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= IDLE;
      target  <= 1'b0;
      applied <= 1'b0;
      done    <= 1'b0;
    end else begin
      s1    <= underclock_req;
      s2    <= s1;
      state <= state_n;
      done  <= state == FINISH;
      if (state == IDLE && state_n == WR_MODE) target <= s2;
      if (state == FINISH) applied <= target;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (s1 == s2 && s2 != applied) ? WR_MODE : IDLE;
      WR_MODE:  state_n = bus.mgmt_waitrequest ? WR_MODE : GAP1;
      GAP1:     state_n = WR_FRAC;
      WR_FRAC:  state_n = bus.mgmt_waitrequest ? WR_FRAC : GAP2;
      GAP2:     state_n = WR_START;
      WR_START: state_n = bus.mgmt_waitrequest ? WR_START : FINISH;
      FINISH:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
`ifdef PLL_SEQ_TIMEOUT_EN
  logic [15:0] cnt;
  // cnt holds stalls already seen in this write; this stall is the last allowed one
  assign abort = wr && bus.mgmt_waitrequest && cnt == TIMEOUT_CYCLES - 16'd1;
  always_ff @(posedge clk_50m or negedge reset)
    if (!reset) begin
      cnt       <= 16'd0;
      cfg_error <= 1'b0;
    end else begin
      cnt <= state_n != state ? 16'd0 : cnt + {15'd0, wr && bus.mgmt_waitrequest};
      if (abort) cfg_error <= 1'b1;
      else if (state == FINISH) cfg_error <= 1'b0;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort = 1'b0;
  assign cfg_error = 1'b0;
`endif
endmodule

// File: tb/tb_pll_underclock_seq.sv
// tb_pll_underclock_seq: directed and randomized checks of pll_underclock_seq
module tb_pll_underclock_seq;
  localparam logic [31:0] NAT = 32'd3639383488;
  localparam logic [31:0] UND = 32'd3268298314;
  localparam int TO = 8;
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int STALL = 5;
`else
  localparam int STALL = 20;
`endif
  typedef struct packed {logic [5:0] a; logic [31:0] d;} wr_t;
  logic clk_50m = 1'b0, reset = 1'b0, underclock_req = 1'b0;
  logic busy, applied, done, cfg_error;
  int checks = 0, errors = 0;
  wr_t log_q[$];
  logic exp_applied, exp_cfg;
  int n_done = 0, bc, stalls, run;
  pll_underclock_seq_if bus();
  pll_underclock_seq #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk_50m(clk_50m), .reset(reset), .underclock_req(underclock_req), .bus(bus),
    .busy(busy), .applied(applied), .done(done), .cfg_error(cfg_error));
  always #10 clk_50m = ~clk_50m;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_seq();
    log_q.delete();
    bc = 0;
    stalls = 0;
    run = 0;
  endtask
  task automatic model_reset();
    clear_seq();
    exp_applied = 1'b0;
    exp_cfg = 1'b0;
  endtask
  // One clock: snapshot what the posedge will see, then judge the result at the negedge.
  // Model: each sequence targets !applied and must log exactly (0,0),(7,frac),(2,0)
  // in 6 + stall cycles; a busy drop without done is a watchdog abort.
  task automatic cycle();
    logic s_wr, s_wait, s_busy;
    logic [5:0] s_a;
    logic [31:0] s_d;
    s_wr = bus.mgmt_write;
    s_wait = bus.mgmt_waitrequest;
    s_busy = busy;
    s_a = bus.mgmt_address;
    s_d = bus.mgmt_writedata;
    @(negedge clk_50m);
    if (s_busy) bc++;
    if (s_wr && s_wait) begin
      stalls++;
      run++;
      if (busy) begin
        chk("hold_write", bus.mgmt_write, 1);
        chk("hold_addr", bus.mgmt_address, s_a);
        chk("hold_data", bus.mgmt_writedata, s_d);
      end
    end
    if (s_wr && !s_wait) begin
      log_q.push_back({s_a, s_d});
      run = 0;
      chk("gap_after_write", bus.mgmt_write, 0);
    end
    if (done) begin
      n_done++;
      chk("seq_writes", log_q.size(), 3);
      if (log_q.size() == 3) begin
        chk("w0_addr", log_q[0].a, 0);
        chk("w0_data", log_q[0].d, 0);
        chk("w1_addr", log_q[1].a, 7);
        chk("w1_data", log_q[1].d, exp_applied ? NAT : UND);
        chk("w2_addr", log_q[2].a, 2);
        chk("w2_data", log_q[2].d, 0);
      end
      chk("seq_cycles", bc, 6 + stalls);
      exp_applied = !exp_applied;
      exp_cfg = 1'b0;
      clear_seq();
    end else if (s_busy && !busy) begin
      chk("abort_stalls", run, TO);
      exp_cfg = 1'b1;
      clear_seq();
    end
    chk("applied", applied, exp_applied);
    chk("cfg_error", cfg_error, exp_cfg);
  endtask
  task automatic wait_done(input int lim);
    int start, n;
    start = n_done;
    n = 0;
    while (n_done == start && n < lim) begin
      cycle();
      n++;
    end
    chk("done_timeout", n_done != start, 1);
  endtask
  task automatic wait_wr(input logic [5:0] a, input int lim);
    int n;
    n = 0;
    while (!(bus.mgmt_write && bus.mgmt_address == a) && n < lim) begin
      cycle();
      n++;
    end
    chk("write_timeout", bus.mgmt_write && bus.mgmt_address == a, 1);
  endtask
  initial begin
    int n7, n;
    bus.mgmt_waitrequest = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_50m);
    chk("rst_write", bus.mgmt_write, 0);
    chk("rst_addr", bus.mgmt_address, 0);
    chk("rst_data", bus.mgmt_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_applied", applied, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg", cfg_error, 0);
    reset = 1'b1;
    repeat (100) begin
      cycle();
      chk("idle_write", bus.mgmt_write, 0);
      chk("idle_busy", busy, 0);
    end
    underclock_req = 1'b1;
    cycle();
    cycle();
    chk("sync_busy_low", busy, 0);
    cycle();
    chk("start_busy", busy, 1);
    chk("start_write", bus.mgmt_write, 1);
    chk("start_addr", bus.mgmt_address, 0);
    wait_done(40);
    chk("under_applied", applied, 1);
    chk("under_done_cnt", n_done, 1);
    underclock_req = 1'b0;
    wait_wr(6'd7, 40);
    n7 = 1;
    bus.mgmt_waitrequest = 1'b1;
    repeat (STALL) begin
      cycle();
      if (bus.mgmt_write && bus.mgmt_address == 6'd7) n7++;
    end
    bus.mgmt_waitrequest = 1'b0;
    cycle();
    chk("stall_len", n7, STALL + 1);
    chk("stall_gap", bus.mgmt_write, 0);
    wait_done(40);
    chk("native_applied", applied, 0);
    underclock_req = 1'b1;
    wait_wr(6'd0, 40);
    cycle();
    chk("gap1_write", bus.mgmt_write, 0);
    underclock_req = 1'b0;
    wait_done(40);
    chk("toggle_first", applied, 1);
    wait_done(60);
    chk("toggle_second", applied, 0);
    underclock_req = 1'b1;
    wait_done(40);
    underclock_req = 1'b0;
    wait_wr(6'd2, 60);
    underclock_req = 1'b1;
    reset = 1'b0;
    #1;
    chk("abort_write", bus.mgmt_write, 0);
    chk("abort_addr", bus.mgmt_address, 0);
    chk("abort_busy", busy, 0);
    chk("abort_applied", applied, 0);
    model_reset();
    cycle();
    cycle();
    reset = 1'b1;
    wait_done(60);
    chk("rerun_applied", applied, 1);
    repeat (30) begin
      underclock_req = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 15)) begin
        bus.mgmt_waitrequest = $urandom_range(0, 3) == 0;
        cycle();
      end
    end
    bus.mgmt_waitrequest = 1'b0;
    repeat (40) cycle();
    chk("rand_final", applied, underclock_req);
    chk("rand_idle", busy, 0);
`ifdef PLL_SEQ_TIMEOUT_EN
    bus.mgmt_waitrequest = 1'b1;
    underclock_req = !exp_applied;
    n = 0;
    while (!cfg_error && n < 60) begin
      cycle();
      n++;
    end
    chk("to_flag", cfg_error, 1);
    n = 0;
    while (!busy && n < 20) begin
      cycle();
      n++;
    end
    chk("to_retry", busy, 1);
    bus.mgmt_waitrequest = 1'b0;
    wait_done(40);
    chk("to_cleared", cfg_error, 0);
    chk("to_applied", applied, underclock_req);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_underclock_seq.md
PLL_UNDERCLOCK_SEQ -- requirements
Module: pll_underclock_seq

Interface
REQ-001 Parameter FRAC_NATIVE, default 32'd3639383488, is the PLL fractional-K word for native speed.
REQ-002 Parameter FRAC_UNDER, default 32'd3268298314, is the PLL fractional-K word for the 60Hz-adjust underclock.
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd4095, is the waitrequest stall limit per write (used only with REQ-030).
REQ-004 clk_50m  in  1  reconfiguration management clock; sole clock of the block.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 underclock_req  in  1  OSD speed select (1 = underclock), asynchronous to clk_50m.
REQ-007 mgmt_waitrequest  in  1  PLL reconfig slave stall.
REQ-008 mgmt_write  out  1  Avalon-MM write strobe to the PLL reconfig slave.
REQ-009 mgmt_address  out  6  register address.
REQ-010 mgmt_writedata  out  32  register data.
REQ-011 busy  out  1  high while a reconfiguration sequence is in progress.
REQ-012 applied  out  1  speed value last written successfully to the PLL.
REQ-013 done  out  1  one-cycle pulse when a sequence completes.
REQ-014 cfg_error  out  1  sticky write-timeout flag.

Function
REQ-015 underclock_req passes through a 2-flop synchronizer (s1, s2); a request is stable when s2 equals s1 on the same cycle.
REQ-016 States: IDLE, WR_MODE, GAP1, WR_FRAC, GAP2, WR_START, FINISH.
REQ-017 In IDLE, a stable request that differs from applied moves to WR_MODE on the next cycle and latches the target value; busy rises on that same edge.
REQ-018 WR_MODE: mgmt_write=1, address 0, data 0 (waitrequest mode); the block holds all three until the first cycle with mgmt_waitrequest=0, which completes the transfer.
REQ-019 GAP1 and GAP2 each last exactly one cycle with mgmt_write=0.
REQ-020 WR_FRAC: address 7, data FRAC_UNDER if target=1, else FRAC_NATIVE; same hold rule as REQ-018.
REQ-021 WR_START: address 2, data 0; same hold rule.
REQ-022 FINISH lasts one cycle: applied takes target, done=1, busy=0 on the following edge, and the state returns to IDLE.
REQ-023 Minimum sequence with waitrequest low throughout: 6 cycles from leaving IDLE to re-entering IDLE.
REQ-024 A request change during a sequence does not disturb it; after FINISH, the REQ-017 comparison re-evaluates and starts a new sequence if the request differs.
REQ-025 mgmt_write is never high for two consecutive transfers without an intervening gap cycle; address and data are stable whenever mgmt_write=1.

Reset
REQ-026 While reset=0: state=IDLE, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, applied=0, done=0, cfg_error=0, synchronizer flops=0.
REQ-027 Reset asserted mid-sequence aborts immediately with no further writes; applied=0 (the PLL powers up native).
REQ-028 After reset release with underclock_req=1, a sequence to FRAC_UNDER starts once the synchronizer is stable.

Configuration
REQ-029 Macro PLL_SEQ_TIMEOUT_EN selects the waitrequest watchdog.
REQ-030 With PLL_SEQ_TIMEOUT_EN defined: a 16-bit counter clears at each write-state entry and increments each cycle that mgmt_waitrequest=1. If it reaches TIMEOUT_CYCLES, the block drops mgmt_write, sets cfg_error, returns to IDLE with applied unchanged, and deasserts busy; the retry follows via REQ-017. cfg_error clears at the next done pulse.
REQ-031 Without PLL_SEQ_TIMEOUT_EN: writes wait indefinitely, no counter logic exists, and cfg_error is tied to 0.

Verification
REQ-032 Reset released with underclock_req=0 and waitrequest=0 -> no mgmt_write for 100 cycles; applied=0, busy=0.
REQ-033 underclock_req 0->1, waitrequest=0 -> writes (0,0), (7,3268298314), (2,0), each one cycle with one-cycle gaps; done pulses once; applied=1.
REQ-034 During WR_FRAC, waitrequest held high 20 cycles -> write, address 7 and data held 21 cycles; sequence then completes normally.
REQ-035 underclock_req toggles 1->0 during GAP1 of a 0->1 sequence -> first sequence completes with applied=1, then a second sequence writes 3639383488 and leaves applied=0.
REQ-036 reset pulsed low during WR_START -> mgmt_write=0 asynchronously; with req=1, a fresh full sequence follows after release.
REQ-037 PLL_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and waitrequest stuck high -> abort after 8 stall cycles, cfg_error=1, applied unchanged, automatic retry; releasing waitrequest lets the retry finish and clears cfg_error.
